busca_minas_core: RTL and testbench

//  Parametrised minesweeper engine: LFSR mine placement, neighbour counts, cursor/flag/reveal play.

---
 rtl/busca_minas_pkg.sv | 79 +++++++
 rtl/busca_minas_core_lfsr.sv | 38 +++
 rtl/busca_minas_core.sv | 207 ++++++++++++++++++++
 tb/tb_busca_minas_core.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_minas_pkg.sv
// Shared types and helpers for the parametrised minesweeper engine.
// Board geometry is bounded at 16x16, so helpers operate on a 256-entry mine map.
package busca_minas_pkg;

  localparam int MAX_CELLS = 256;

  typedef enum logic [2:0] {
    StIdle,
    StPlace,
    StCount,
    StPlay,
    StLost,
    StWon
  } state_t;

  typedef struct packed {
    logic       revealed;
    logic       flagged;
    logic       mine;
    logic [3:0] count;
  } cell_t;

  // Right-shifting Galois masks giving a maximal-length sequence per width.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0007_2000;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  // Mines among the 8 neighbours of (r, c); board edges do not wrap.
  function automatic logic [3:0] nbr_count(input logic [MAX_CELLS-1:0] mine_map, input int r,
                                           input int c, input int rows, input int cols);
    logic [3:0] n;
    int rr;
    int cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if ((dr != 0 || dc != 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols) begin
          if (mine_map[8'(rr * cols + cc)]) n = n + 4'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/busca_minas_core_lfsr.sv
// Galois LFSR used as the mine placement source; a zero seed is forced to 1
// so the register can never lock up.
module lfsr_gen
  import busca_minas_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] value
);

  localparam logic [31:0] TapsFull = lfsr_taps(W);
  localparam logic [W-1:0] Taps = TapsFull[W-1:0];

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == '0) ? W'(1) : seed;
    end else if (enable) begin
      value_d = value_q[0] ? ((value_q >> 1) ^ Taps) : (value_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= W'(1);
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/busca_minas_core.sv
// Minesweeper engine: LFSR mine placement, neighbour count scan, cursor/flag/reveal
// play with win/lose detection, and a combinational cell read port for the renderer.
module busca_minas_core
  import busca_minas_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int LFSR_W = 16,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NW = $clog2(ROWS * COLS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [NW-1:0]     total_mines,
  input  logic              mov,
  input  logic              sel_flag,
  input  logic              sel,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [7:0]        rd_cell,
  output logic [RW-1:0]     cursor_row,
  output logic [CW-1:0]     cursor_col,
  output logic [RW-1:0]     random_row,
  output logic [CW-1:0]     random_col,
  output logic              busy,
  output logic              game_over,
  output logic              game_won
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW = $clog2(CELLS);
  localparam logic [NW-1:0] MaxMines = NW'(CELLS - 1);

  state_t state_q, state_d;
  cell_t  cells_q [CELLS];

  logic [RW-1:0] cur_row_q, scan_row_q, rnd_row_q;
  logic [CW-1:0] cur_col_q, scan_col_q, rnd_col_q;
  logic [NW-1:0] placed_q, mines_q, revealed_q, mines_req, safe_cells;
  logic [LFSR_W-1:0] lfsr_val;
  logic [RW-1:0] cand_row;
  logic [CW-1:0] cand_col;
  logic [IW-1:0] cand_idx, cur_idx, scan_idx;
  logic cand_ok, place_hit, scan_last, do_sel, do_flag, do_mov;
  logic [MAX_CELLS-1:0] mine_map;
  cell_t cur_cell, rd_v;
  logic unused_lfsr;

  function automatic logic [IW-1:0] idx_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return IW'(int'(r) * COLS + int'(c));
  endfunction

  lfsr_gen #(
    .W(LFSR_W)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q == StPlace),
    .load  (start),
    .seed  (seed),
    .value (lfsr_val)
  );

  assign cand_row    = lfsr_val[RW-1:0];
  assign cand_col    = lfsr_val[RW+CW-1:RW];
  assign unused_lfsr = ^lfsr_val[LFSR_W-1:RW+CW];

  always_comb begin
    mine_map = '0;
    for (int i = 0; i < CELLS; i++) mine_map[i] = cells_q[i].mine;
  end

  always_comb begin
    cand_ok  = 1'b0;
    cand_idx = '0;
    if (int'(cand_row) < ROWS && int'(cand_col) < COLS) begin
      cand_idx = idx_of(cand_row, cand_col);
      cand_ok  = !cells_q[cand_idx].mine;
    end
  end

  assign place_hit  = (state_q == StPlace) && (placed_q != mines_q) && cand_ok;
  assign cur_idx    = idx_of(cur_row_q, cur_col_q);
  assign cur_cell   = cells_q[cur_idx];
  assign scan_idx   = idx_of(scan_row_q, scan_col_q);
  assign scan_last  = (scan_idx == IW'(CELLS - 1));
  assign safe_cells = NW'(CELLS) - mines_q;

  always_comb begin
    mines_req = total_mines;
    if (total_mines == '0)           mines_req = NW'(1);
    else if (total_mines > MaxMines) mines_req = MaxMines;
  end

  // Pulse priority: sel shadows sel_flag, which shadows mov, even when the winner is a no-op.
  always_comb begin
    do_sel  = 1'b0;
    do_flag = 1'b0;
    do_mov  = 1'b0;
    if (state_q == StPlay && !start) begin
      if (sel)           do_sel  = !cur_cell.flagged && !cur_cell.revealed;
      else if (sel_flag) do_flag = !cur_cell.revealed;
      else               do_mov  = mov;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StPlace: if (placed_q == mines_q) state_d = StCount;
      StCount: if (scan_last) state_d = StPlay;
      StPlay: begin
        if (do_sel) begin
          if (cur_cell.mine)                        state_d = StLost;
          else if (revealed_q + NW'(1) == safe_cells) state_d = StWon;
        end
      end
      default: ;
    endcase
    if (start) state_d = StPlace;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) cells_q[i] <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      scan_row_q <= '0;
      scan_col_q <= '0;
      rnd_row_q  <= '0;
      rnd_col_q  <= '0;
      placed_q   <= '0;
      mines_q    <= '0;
      revealed_q <= '0;
    end else if (start) begin
      for (int i = 0; i < CELLS; i++) cells_q[i] <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      scan_row_q <= '0;
      scan_col_q <= '0;
      placed_q   <= '0;
      revealed_q <= '0;
      mines_q    <= mines_req;
    end else begin
      if (state_q == StPlace) begin
        rnd_row_q <= cand_row;
        rnd_col_q <= cand_col;
      end
      if (place_hit) begin
        cells_q[cand_idx].mine <= 1'b1;
        placed_q <= placed_q + NW'(1);
      end
      if (state_q == StCount) begin
        cells_q[scan_idx].count <= nbr_count(mine_map, int'(scan_row_q), int'(scan_col_q),
                                             ROWS, COLS);
        if (scan_last) begin
          scan_row_q <= '0;
          scan_col_q <= '0;
        end else if (scan_col_q == CW'(COLS - 1)) begin
          scan_col_q <= '0;
          scan_row_q <= scan_row_q + RW'(1);
        end else begin
          scan_col_q <= scan_col_q + CW'(1);
        end
      end
      if (do_sel) begin
        cells_q[cur_idx].revealed <= 1'b1;
        if (!cur_cell.mine) revealed_q <= revealed_q + NW'(1);
      end
      if (do_flag) cells_q[cur_idx].flagged <= !cur_cell.flagged;
      if (do_mov) begin
        if (cur_col_q == CW'(COLS - 1)) begin
          cur_col_q <= '0;
          cur_row_q <= (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
        end else begin
          cur_col_q <= cur_col_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_v    = '0;
    rd_cell = '0;
    if (int'(rd_row) < ROWS && int'(rd_col) < COLS) begin
      rd_v    = cells_q[idx_of(rd_row, rd_col)];
      rd_cell = {rd_v.revealed, rd_v.flagged, rd_v.mine, 1'b0, rd_v.count};
    end
  end

  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign random_row = rnd_row_q;
  assign random_col = rnd_col_q;
  assign busy       = (state_q == StPlace) || (state_q == StCount);
  assign game_over  = (state_q == StLost);
  assign game_won   = (state_q == StWon);

endmodule

// File: tb/tb_busca_minas_core.sv
// Directed bench for busca_minas_core: one 8x8 and one 5x12 instance, same scenario on each.
module tb_busca_minas_core;

  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        start_s [2];
  logic        mov_s   [2];
  logic        flag_s  [2];
  logic        sel_s   [2];
  logic [15:0] seed_s  [2];
  logic [6:0]  tm_s    [2];
  logic [3:0]  rr_s    [2];
  logic [3:0]  rc_s    [2];
  logic        busy_o  [2];
  logic        over_o  [2];
  logic        won_o   [2];
  logic [7:0]  cell_o  [2];
  logic [3:0]  cr_o    [2];
  logic [3:0]  cc_o    [2];

  logic [7:0] cell0, cell1;
  logic [2:0] cr0, cc0, cr1, rndr0, rndc0, rndr1;
  logic [3:0] cc1, rndc1;

  busca_minas_core #(.ROWS(8), .COLS(8), .LFSR_W(16)) u_d0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .seed(seed_s[0]),
    .total_mines(tm_s[0][6:0]), .mov(mov_s[0]), .sel_flag(flag_s[0]), .sel(sel_s[0]),
    .rd_row(rr_s[0][2:0]), .rd_col(rc_s[0][2:0]), .rd_cell(cell0),
    .cursor_row(cr0), .cursor_col(cc0), .random_row(rndr0), .random_col(rndc0),
    .busy(busy_o[0]), .game_over(over_o[0]), .game_won(won_o[0])
  );

  busca_minas_core #(.ROWS(5), .COLS(12), .LFSR_W(16)) u_d1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .seed(seed_s[1]),
    .total_mines(tm_s[1][5:0]), .mov(mov_s[1]), .sel_flag(flag_s[1]), .sel(sel_s[1]),
    .rd_row(rr_s[1][2:0]), .rd_col(rc_s[1][3:0]), .rd_cell(cell1),
    .cursor_row(cr1), .cursor_col(cc1), .random_row(rndr1), .random_col(rndc1),
    .busy(busy_o[1]), .game_over(over_o[1]), .game_won(won_o[1])
  );

  assign cell_o[0] = cell0;
  assign cell_o[1] = cell1;
  assign cr_o[0]   = {1'b0, cr0};
  assign cc_o[0]   = {1'b0, cc0};
  assign cr_o[1]   = {1'b0, cr1};
  assign cc_o[1]   = cc1;

  int checks = 0;
  int errors = 0;
  logic [7:0] board [16][16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // kind: 0 start, 1 mov, 2 sel_flag, 3 sel, 4 sel+mov together
  task automatic pulse(input int d, input int kind);
    case (kind)
      0: start_s[d] = 1'b1;
      1: mov_s[d] = 1'b1;
      2: flag_s[d] = 1'b1;
      3: sel_s[d] = 1'b1;
      default: begin
        sel_s[d] = 1'b1;
        mov_s[d] = 1'b1;
      end
    endcase
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    mov_s[d]   = 1'b0;
    flag_s[d]  = 1'b0;
    sel_s[d]   = 1'b0;
  endtask

  task automatic read_one(input int d, input int r, input int c, output logic [7:0] v);
    rr_s[d] = 4'(r);
    rc_s[d] = 4'(c);
    #1;
    v = cell_o[d];
  endtask

  task automatic read_board(input int d, input int rows, input int cols);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) read_one(d, r, c, board[r][c]);
  endtask

  function automatic int count_bit(input int rows, input int cols, input int b);
    int n = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) if (board[r][c][b]) n++;
    return n;
  endfunction

  function automatic int count_nonzero(input int rows, input int cols);
    int n = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) if (board[r][c] != 8'h00) n++;
    return n;
  endfunction

  // Independent neighbour recount from the mine bits; returns number of wrong cells.
  function automatic int recount_bad(input int rows, input int cols);
    int bad = 0;
    int n;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < rows && c + dc >= 0 &&
                c + dc < cols && board[r+dr][c+dc][5]) n++;
        if (int'(board[r][c][3:0]) != n || board[r][c][4] !== 1'b0) bad++;
      end
    end
    return bad;
  endfunction

  task automatic wait_idle(input int d, output int cyc);
    cyc = 0;
    while (busy_o[d] === 1'b1 && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic new_game(input int d, input logic [15:0] sd, input int tm, output int cyc);
    seed_s[d] = sd;
    tm_s[d]   = 7'(tm);
    pulse(d, 0);
    chk($sformatf("d%0d_busy_after_start_tm%0d", d, tm), busy_o[d], 1);
    wait_idle(d, cyc);
    chk($sformatf("d%0d_no_deadlock_tm%0d", d, tm), cyc < LIMIT, 1);
  endtask

  task automatic run_suite(input int d);
    int rows, cols, n, cyc, tgt, safe_left, pr, pc;
    logic first;
    logic [7:0] v;
    rows = (d == 0) ? 8 : 5;
    cols = (d == 0) ? 8 : 12;
    n = rows * cols;

    chk($sformatf("d%0d_rst_busy", d), busy_o[d], 0);
    chk($sformatf("d%0d_rst_over", d), over_o[d], 0);
    chk($sformatf("d%0d_rst_won", d), won_o[d], 0);
    chk($sformatf("d%0d_rst_cursor", d), {cr_o[d], cc_o[d]}, 0);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_rst_cells_zero", d), count_nonzero(rows, cols), 0);

    // Main game: 10 mines from seed ACE1.
    new_game(d, 16'hACE1, 10, cyc);
    chk($sformatf("d%0d_busy_len_ge_place_plus_scan", d), cyc >= n + 11, 1);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_mines10", d), count_bit(rows, cols, 5), 10);
    chk($sformatf("d%0d_counts10", d), recount_bad(rows, cols), 0);
    chk($sformatf("d%0d_fresh_no_flags_reveals", d), count_bit(rows, cols, 7) +
        count_bit(rows, cols, 6), 0);

    // Flag protects a mine; unflagged sel on it loses.
    tgt = 0;
    while (tgt < n && !board[tgt/cols][tgt%cols][5]) tgt++;
    repeat (tgt) pulse(d, 1);
    chk($sformatf("d%0d_cursor_at_mine", d), {cr_o[d], cc_o[d]},
        {4'(tgt / cols), 4'(tgt % cols)});
    pulse(d, 2);
    pulse(d, 3);
    read_one(d, tgt / cols, tgt % cols, v);
    chk($sformatf("d%0d_flagged_mine_not_revealed", d), v[7:5], 3'b011);
    chk($sformatf("d%0d_flagged_sel_no_loss", d), over_o[d], 0);
    pulse(d, 2);
    pulse(d, 3);
    read_one(d, tgt / cols, tgt % cols, v);
    chk($sformatf("d%0d_mine_revealed", d), v[7:5], 3'b101);
    chk($sformatf("d%0d_lost", d), over_o[d], 1);
    pulse(d, 1);
    pulse(d, 2);
    pulse(d, 1);
    chk($sformatf("d%0d_lost_cursor_frozen", d), {cr_o[d], cc_o[d]},
        {4'(tgt / cols), 4'(tgt % cols)});
    read_board(d, rows, cols);
    chk($sformatf("d%0d_lost_board_frozen", d), count_bit(rows, cols, 7) * 100 +
        count_bit(rows, cols, 6), 100);
    chk($sformatf("d%0d_lost_not_won", d), won_o[d], 0);

    // Same seed replays the same board; reveal every safe cell to win.
    new_game(d, 16'hACE1, 10, cyc);
    chk($sformatf("d%0d_restart_clears_over", d), over_o[d], 0);
    chk($sformatf("d%0d_restart_cursor", d), {cr_o[d], cc_o[d]}, 0);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_replay_mines", d), count_bit(rows, cols, 5), 10);
    safe_left = n - 10;
    first = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!board[i/cols][i%cols][5]) begin
        if (safe_left == 1) chk($sformatf("d%0d_not_won_before_last", d), won_o[d], 0);
        if (first) begin
          pulse(d, 4);
          chk($sformatf("d%0d_sel_beats_mov", d), {cr_o[d], cc_o[d]},
              {4'(i / cols), 4'(i % cols)});
          first = 1'b0;
        end else begin
          pulse(d, 3);
        end
        safe_left--;
      end
      if (i < n - 1) pulse(d, 1);
    end
    chk($sformatf("d%0d_won", d), won_o[d], 1);
    chk($sformatf("d%0d_won_not_over", d), over_o[d], 0);
    pr = int'(cr_o[d]);
    pc = int'(cc_o[d]);
    pulse(d, 1);
    chk($sformatf("d%0d_won_cursor_frozen", d), {cr_o[d], cc_o[d]}, {4'(pr), 4'(pc)});
    read_board(d, rows, cols);
    chk($sformatf("d%0d_won_revealed", d), count_bit(rows, cols, 7), n - 10);
    if (d == 1) begin
      read_one(d, 5, 0, v);
      chk("d1_rd_row_out_of_range", v, 0);
      read_one(d, 0, 12, v);
      chk("d1_rd_col_out_of_range", v, 0);
    end

    // Mine count clamping at both ends.
    new_game(d, 16'h1234, 0, cyc);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_clamp_low", d), count_bit(rows, cols, 5), 1);
    chk($sformatf("d%0d_clamp_low_counts", d), recount_bad(rows, cols), 0);
    new_game(d, 16'h0000, (d == 0) ? 64 : 63, cyc);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_clamp_high", d), count_bit(rows, cols, 5), n - 1);
    chk($sformatf("d%0d_clamp_high_counts", d), recount_bad(rows, cols), 0);

    // Cursor wrap.
    repeat (n) pulse(d, 1);
    chk($sformatf("d%0d_full_wrap", d), {cr_o[d], cc_o[d]}, 0);
    repeat (cols) pulse(d, 1);
    chk($sformatf("d%0d_row_wrap", d), {cr_o[d], cc_o[d]}, {4'd1, 4'd0});

    // Restart while the first game is still scanning.
    seed_s[d] = 16'hACE1;
    tm_s[d]   = 7'd1;
    pulse(d, 0);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("d%0d_busy_before_restart", d), busy_o[d], 1);
    new_game(d, 16'hACE1, 10, cyc);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_restart_mines", d), count_bit(rows, cols, 5), 10);
    chk($sformatf("d%0d_restart_counts", d), recount_bad(rows, cols), 0);
    chk($sformatf("d%0d_restart_cursor0", d), {cr_o[d], cc_o[d]}, 0);

    // Asynchronous reset in the middle of play.
    repeat (3) pulse(d, 1);
    pulse(d, 2);
    #2;
    rst_s[d] = 1'b1;
    #1;
    chk($sformatf("d%0d_midrst_busy", d), busy_o[d], 0);
    chk($sformatf("d%0d_midrst_flags", d), {over_o[d], won_o[d]}, 0);
    chk($sformatf("d%0d_midrst_cursor", d), {cr_o[d], cc_o[d]}, 0);
    read_board(d, rows, cols);
    chk($sformatf("d%0d_midrst_cells", d), count_nonzero(rows, cols), 0);
    rst_s[d] = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("d%0d_idle_after_rst", d), busy_o[d], 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d]   = 1'b1;
      start_s[d] = 1'b0;
      mov_s[d]   = 1'b0;
      flag_s[d]  = 1'b0;
      sel_s[d]   = 1'b0;
      seed_s[d]  = 16'h0;
      tm_s[d]    = 7'd0;
      rr_s[d]    = 4'd0;
      rc_s[d]    = 4'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    @(posedge clk);
    #1;
    run_suite(0);
    run_suite(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
